// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage: FSM encoding,
// default reset vector, PC increment and the buffered instr/pc entry.
package fetch_stage_pkg;

   localparam logic [31:0] FETCH_RESET_PC = 32'hBFC0_0000;
   localparam logic [31:0] PC_INC         = 32'd4;

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_HOLD = 2'd1,
      ST_KILL = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & ~32'h3;
   endfunction

endpackage

// File: rtl/fetch_stage_skid_buf.sv
// fetch_skid_buf: one-entry instr/pc holding register for a fetch that returns
// while decode is stalled. Clear and unload both empty it; clear wins over load.
module fetch_skid_buf
   import fetch_stage_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic         i_unload,
   input  logic         i_clear,
   input  fetch_entry_t i_entry,
   output logic         o_valid,
   output fetch_entry_t o_entry
);

   logic         r_valid;
   fetch_entry_t r_entry;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_entry <= '0;
      end else begin
         if (i_clear || i_unload)
            r_valid <= 1'b0;
         else if (i_load)
            r_valid <= 1'b1;
         if (i_load && !i_clear)
            r_entry <= i_entry;
      end
   end

   assign o_valid = r_valid;
   assign o_entry = r_entry;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage with a single-outstanding req/ack fetch, skid buffer
// and decode redirects. Define FETCH_DELAY_SLOT_EN for delay-slot redirect semantics.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallF,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_ack,
   input  logic [31:0] inst_rdata,
   output logic        instrF_valid,
   output logic [31:0] instrF,
   output logic [31:0] pcF
);

   fetch_state_e r_state, w_state_nxt;
   logic         r_req, r_valid_q;
   logic [31:0]  r_req_addr, r_pc, r_instr, r_pcF;
   logic [31:0]  w_pc_nxt, w_req_addr_nxt, w_pc_inc, w_tgt;
   logic         w_ack, w_redir, w_flush, w_valid_nxt, w_out_ld;
   logic         w_buf_ld, w_buf_unld, w_buf_valid;
   fetch_entry_t w_mem_entry, w_out_entry, w_buf_entry;
`ifdef FETCH_DELAY_SLOT_EN
   logic         r_pend_redir;
   logic [31:0]  r_pend_pc;
   logic         w_pend_set, w_pend_clr;
`endif

   // An ack only counts while a request is actually on the bus.
   assign w_ack       = inst_ack & r_req;
   assign w_redir     = redirect_valid & ~stallF;
   assign w_tgt       = word_align(redirect_pc);
   assign w_pc_inc    = r_pc + PC_INC;
   assign w_mem_entry = '{instr: inst_rdata, pc: r_req_addr};

   // Flush = wrong-path work must be dropped. With delay slots that is only when
   // the slot is the instruction being consumed now.
`ifdef FETCH_DELAY_SLOT_EN
   assign w_flush = w_redir & r_valid_q;
`else
   assign w_flush = w_redir;
`endif

   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_req_addr_nxt = r_req_addr;
      w_out_ld       = 1'b0;
      w_out_entry    = w_mem_entry;
      w_buf_ld       = 1'b0;
      w_buf_unld     = 1'b0;
`ifdef FETCH_DELAY_SLOT_EN
      w_pend_set     = 1'b0;
      w_pend_clr     = 1'b0;
`endif
      case (r_state)
         ST_REQ: begin
            if (w_flush) begin
               w_pc_nxt = w_tgt;
               if (w_ack)
                  w_req_addr_nxt = w_tgt;
               else
                  w_state_nxt = ST_KILL;
            end else if (w_ack) begin
               w_pc_nxt = w_pc_inc;
               if (!stallF || !r_valid_q) begin
                  w_out_ld = 1'b1;
`ifdef FETCH_DELAY_SLOT_EN
                  w_pend_clr = 1'b1;
                  if (w_redir)
                     w_pc_nxt = w_tgt;
                  else if (r_pend_redir)
                     w_pc_nxt = r_pend_pc;
`endif
               end else begin
                  w_buf_ld    = 1'b1;
                  w_state_nxt = ST_HOLD;
               end
               w_req_addr_nxt = w_pc_nxt;
            end
`ifdef FETCH_DELAY_SLOT_EN
            else if (w_redir)
               w_pend_set = 1'b1;
`endif
         end
         ST_HOLD: begin
            if (w_flush) begin
               w_pc_nxt       = w_tgt;
               w_req_addr_nxt = w_tgt;
               w_state_nxt    = ST_REQ;
            end else if (!stallF && w_buf_valid) begin
               w_out_ld    = 1'b1;
               w_out_entry = w_buf_entry;
               w_buf_unld  = 1'b1;
               w_state_nxt = ST_REQ;
            end
         end
         ST_KILL: begin
            // The abandoned request stays on the bus until memory answers it.
            if (w_redir)
               w_pc_nxt = w_tgt;
            if (w_ack) begin
               w_req_addr_nxt = w_pc_nxt;
               w_state_nxt    = ST_REQ;
            end
         end
         default: w_state_nxt = ST_REQ;
      endcase
      w_valid_nxt = w_out_ld ? 1'b1 : (stallF ? r_valid_q : 1'b0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_REQ;
         r_req      <= 1'b0;
         r_req_addr <= RESET_PC;
         r_pc       <= RESET_PC;
         r_valid_q  <= 1'b0;
         r_instr    <= '0;
         r_pcF      <= '0;
`ifdef FETCH_DELAY_SLOT_EN
         r_pend_redir <= 1'b0;
         r_pend_pc    <= '0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_req      <= (w_state_nxt != ST_HOLD);
         r_req_addr <= w_req_addr_nxt;
         r_pc       <= w_pc_nxt;
         r_valid_q  <= w_valid_nxt;
         if (w_out_ld) begin
            r_instr <= w_out_entry.instr;
            r_pcF   <= w_out_entry.pc;
         end
`ifdef FETCH_DELAY_SLOT_EN
         if (w_pend_set) begin
            r_pend_redir <= 1'b1;
            r_pend_pc    <= w_tgt;
         end else if (w_pend_clr) begin
            r_pend_redir <= 1'b0;
         end
`endif
      end
   end

   fetch_skid_buf u_skid (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_buf_ld),
      .i_unload (w_buf_unld),
      .i_clear  (w_flush),
      .i_entry  (w_mem_entry),
      .o_valid  (w_buf_valid),
      .o_entry  (w_buf_entry)
   );

   assign inst_req     = r_req;
   assign inst_addr    = r_req_addr;
   assign instrF_valid = r_valid_q;
   assign instrF       = r_instr;
   assign pcF          = r_pcF;

endmodule
